// File: rtl/noc_pkg.sv
// Shared types and helpers for the spiking-neuron NoC mesh router.
// Port indices, direction enum, flit field access and XY routing.
package noc_pkg;

  localparam int N_PORTS = 5;
  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_S = 3;
  localparam int P_W = 4;

  typedef enum logic [2:0] {
    DIR_L = 3'd0,
    DIR_N = 3'd1,
    DIR_E = 3'd2,
    DIR_S = 3'd3,
    DIR_W = 3'd4
  } dir_e;

  localparam int FLIT_MAX_W = 64;
  typedef logic [FLIT_MAX_W-1:0] flit_ext_t;

  function automatic flit_ext_t flit_field(
    flit_ext_t f,
    int        lsb,
    int        w
  );
    flit_ext_t m;
    m = (flit_ext_t'(1) << w) - flit_ext_t'(1);
    return (f >> lsb) & m;
  endfunction

  function automatic int flit_dst_x(
    flit_ext_t f,
    int        coord_w,
    int        payload_w
  );
    return int'(flit_field(f, coord_w + payload_w, coord_w));
  endfunction

  function automatic int flit_dst_y(
    flit_ext_t f,
    int        coord_w,
    int        payload_w
  );
    return int'(flit_field(f, payload_w, coord_w));
  endfunction

  function automatic flit_ext_t flit_payload(
    flit_ext_t f,
    int        payload_w
  );
    return flit_field(f, 0, payload_w);
  endfunction

  // Column is resolved before row.
  function automatic dir_e xy_route(
    int dst_x,
    int dst_y,
    int x_id,
    int y_id
  );
    if (dst_y > y_id) return DIR_E;
    if (dst_y < y_id) return DIR_W;
    if (dst_x > x_id) return DIR_S;
    if (dst_x < x_id) return DIR_N;
    return DIR_L;
  endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Per-input flit FIFO for the mesh router.
// Full/empty come from the registered count only; no bypass path.
module noc_in_fifo #(
  parameter int FLIT_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] din,
  output logic [FLIT_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     wr_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/mesh_router.sv
// Five-port XY mesh router with per-input FIFOs, round-robin
// output arbitration and a saturating drop counter.
module mesh_router
  import noc_pkg::*;
#(
  parameter int X_ID       = 1,
  parameter int Y_ID       = 1,
  parameter int COORD_W    = 4,
  parameter int PAYLOAD_W  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic rt_clk,
  input  logic rt_reset,
  input  logic [2*COORD_W+PAYLOAD_W-1:0] north_in,
  input  logic [2*COORD_W+PAYLOAD_W-1:0] south_in,
  input  logic [2*COORD_W+PAYLOAD_W-1:0] east_in,
  input  logic [2*COORD_W+PAYLOAD_W-1:0] west_in,
  input  logic [2*COORD_W+PAYLOAD_W-1:0] local_in,
  input  logic write_en_north,
  input  logic write_en_south,
  input  logic write_en_east,
  input  logic write_en_west,
  input  logic write_en_local,
  output logic north_full,
  output logic south_full,
  output logic east_full,
  output logic west_full,
  output logic local_full,
  output logic [2*COORD_W+PAYLOAD_W-1:0] north_out,
  output logic [2*COORD_W+PAYLOAD_W-1:0] south_out,
  output logic [2*COORD_W+PAYLOAD_W-1:0] east_out,
  output logic [2*COORD_W+PAYLOAD_W-1:0] west_out,
  output logic [2*COORD_W+PAYLOAD_W-1:0] local_out,
  output logic write_req_north,
  output logic write_req_south,
  output logic write_req_east,
  output logic write_req_west,
  output logic write_req_local,
  input  logic north_neighbor_full,
  input  logic south_neighbor_full,
  input  logic east_neighbor_full,
  input  logic west_neighbor_full,
  input  logic local_neighbor_full,
  output logic [7:0] drop_cnt
);

  localparam int FLIT_W = 2*COORD_W+PAYLOAD_W;

  logic [FLIT_W-1:0]  in_f   [N_PORTS];
  logic [FLIT_W-1:0]  head   [N_PORTS];
  logic [FLIT_W-1:0]  out_f  [N_PORTS];
  logic [FLIT_W-1:0]  last_q [N_PORTS];
  dir_e               route  [N_PORTS];
  logic [2:0]         ptr_q  [N_PORTS];
  logic [2:0]         gnt_idx[N_PORTS];
  logic [N_PORTS-1:0] wr_en;
  logic [N_PORTS-1:0] nb_full;
  logic [N_PORTS-1:0] f_full;
  logic [N_PORTS-1:0] f_empty;
  logic [N_PORTS-1:0] push;
  logic [N_PORTS-1:0] pop;
  logic [N_PORTS-1:0] misroute;
  logic [N_PORTS-1:0] ovf;
  logic [N_PORTS-1:0] gnt_v;
  logic [3:0]         drop_inc;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_q;

  assign in_f[P_L] = local_in;
  assign in_f[P_N] = north_in;
  assign in_f[P_E] = east_in;
  assign in_f[P_S] = south_in;
  assign in_f[P_W] = west_in;

  assign wr_en = {write_en_west, write_en_south,
                  write_en_east, write_en_north,
                  write_en_local};

  assign nb_full = {west_neighbor_full,
                    south_neighbor_full,
                    east_neighbor_full,
                    north_neighbor_full,
                    local_neighbor_full};

  for (genvar i = 0; i < N_PORTS; i++) begin : g_in
    noc_in_fifo #(
      .FLIT_W    (FLIT_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (rt_clk),
      .rst  (rt_reset),
      .push (push[i]),
      .pop  (pop[i]),
      .din  (in_f[i]),
      .head (head[i]),
      .full (f_full[i]),
      .empty(f_empty[i])
    );

    assign route[i] = xy_route(
      flit_dst_x(flit_ext_t'(head[i]), COORD_W, PAYLOAD_W),
      flit_dst_y(flit_ext_t'(head[i]), COORD_W, PAYLOAD_W),
      X_ID, Y_ID);

    // A flit heading back where it came from is discarded.
    assign misroute[i] = !f_empty[i] && (i != P_L)
                         && (route[i] == dir_e'(i));
    assign push[i] = wr_en[i] && !f_full[i];
    assign ovf[i]  = wr_en[i] && f_full[i];
  end

  always_comb begin
    int c;
    c     = 0;
    gnt_v = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      gnt_idx[o] = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        c = (int'(ptr_q[o]) + k) % N_PORTS;
        if (!gnt_v[o] && !nb_full[o] && !f_empty[c]
            && !misroute[c] && route[c] == dir_e'(o)) begin
          gnt_v[o]   = 1'b1;
          gnt_idx[o] = 3'(c);
        end
      end
    end
  end

  always_comb begin
    pop = misroute;
    for (int o = 0; o < N_PORTS; o++) begin
      if (gnt_v[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      out_f[o] = gnt_v[o] ? head[gnt_idx[o]] : last_q[o];
    end
  end

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      drop_inc = drop_inc + 4'(ovf[i]) + 4'(misroute[i]);
    end
    drop_sum = {1'b0, drop_q} + 9'(drop_inc);
  end

  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      drop_q <= '0;
      for (int o = 0; o < N_PORTS; o++) begin
        ptr_q[o]  <= '0;
        last_q[o] <= '0;
      end
    end else begin
      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      for (int o = 0; o < N_PORTS; o++) begin
        if (gnt_v[o]) begin
          ptr_q[o]  <= (gnt_idx[o] == 3'd4) ? 3'd0
                       : gnt_idx[o] + 3'd1;
          last_q[o] <= head[gnt_idx[o]];
        end
      end
    end
  end

  assign drop_cnt = drop_q;

  assign local_full = f_full[P_L];
  assign north_full = f_full[P_N];
  assign east_full  = f_full[P_E];
  assign south_full = f_full[P_S];
  assign west_full  = f_full[P_W];

  assign local_out = out_f[P_L];
  assign north_out = out_f[P_N];
  assign east_out  = out_f[P_E];
  assign south_out = out_f[P_S];
  assign west_out  = out_f[P_W];

  assign write_req_local = gnt_v[P_L];
  assign write_req_north = gnt_v[P_N];
  assign write_req_east  = gnt_v[P_E];
  assign write_req_south = gnt_v[P_S];
  assign write_req_west  = gnt_v[P_W];

endmodule

// File: tb/tb_mesh_router.sv
// Scoreboard bench for mesh_router at (1,1): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_mesh_router;

  localparam int FW = 16;

  logic              clk;
  logic              rst;
  logic [4:0][FW-1:0] in_f;
  logic [4:0][FW-1:0] out_f;
  logic [4:0]        we;
  logic [4:0]        nbf;
  logic [4:0]        wreq;
  logic [4:0]        full;
  logic [7:0]        drop;

  int checks;
  int errors;
  int exp_drop;

  // Expected flits per output; sq holds the source input of each.
  logic [FW-1:0] fq [5][$];
  int            sq [5][$];

  mesh_router #(
    .X_ID(1), .Y_ID(1), .COORD_W(4),
    .PAYLOAD_W(8), .FIFO_DEPTH(4)
  ) dut (
    .rt_clk(clk), .rt_reset(rst),
    .north_in(in_f[1]), .south_in(in_f[3]),
    .east_in(in_f[2]), .west_in(in_f[4]),
    .local_in(in_f[0]),
    .write_en_north(we[1]), .write_en_south(we[3]),
    .write_en_east(we[2]), .write_en_west(we[4]),
    .write_en_local(we[0]),
    .north_full(full[1]), .south_full(full[3]),
    .east_full(full[2]), .west_full(full[4]),
    .local_full(full[0]),
    .north_out(out_f[1]), .south_out(out_f[3]),
    .east_out(out_f[2]), .west_out(out_f[4]),
    .local_out(out_f[0]),
    .write_req_north(wreq[1]), .write_req_south(wreq[3]),
    .write_req_east(wreq[2]), .write_req_west(wreq[4]),
    .write_req_local(wreq[0]),
    .north_neighbor_full(nbf[1]),
    .south_neighbor_full(nbf[3]),
    .east_neighbor_full(nbf[2]),
    .west_neighbor_full(nbf[4]),
    .local_neighbor_full(nbf[0]),
    .drop_cnt(drop)
  );

  always #5 clk = ~clk;

  function automatic int ref_route(int dx, int dy);
    if (dy > 1) return 2;
    if (dy < 1) return 4;
    if (dx > 1) return 3;
    if (dx < 1) return 1;
    return 0;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int o = 0; o < 5; o++) n += fq[o].size();
    return n;
  endfunction

  task automatic chk(string nm, logic [79:0] act,
                     logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic stage(int p, int dx, int dy, int pl,
                       bit acc);
    logic [FW-1:0] f;
    int r;
    f = {4'(dx), 4'(dy), 8'(pl)};
    in_f[p] = f;
    we[p]   = 1'b1;
    if (!acc) exp_drop++;
    else begin
      r = ref_route(dx, dy);
      if (p != 0 && r == p) exp_drop++;
      else begin
        fq[r].push_back(f);
        sq[r].push_back(p);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    we = '0;
  endtask

  task automatic pulse_reset(string nm);
    #2;
    rst = 1'b1;
    #1;
    chk({nm, "_wreq"}, 80'(wreq), 80'd0);
    chk({nm, "_full"}, 80'(full), 80'd0);
    chk({nm, "_drop"}, 80'(drop), 80'd0);
    chk({nm, "_out"}, 80'(out_f), 80'd0);
    exp_drop = 0;
    for (int o = 0; o < 5; o++) begin
      fq[o].delete();
      sq[o].delete();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Any front-of-line flit per source may legally appear next.
  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < 5; o++) begin
        if (wreq[o]) begin
          bit       hit;
          bit [4:0] seen;
          hit  = 1'b0;
          seen = '0;
          for (int j = 0; j < fq[o].size() && !hit; j++) begin
            if (!seen[sq[o][j]] && fq[o][j] == out_f[o]) begin
              hit = 1'b1;
              fq[o].delete(j);
              sq[o].delete(j);
            end else begin
              seen[sq[o][j]] = 1'b1;
            end
          end
          checks++;
          if (!hit) begin
            errors++;
            $display("FAIL deliver port=%0d act=%h pending=%0d",
                     o, out_f[o], fq[o].size());
          end
          checks++;
          if (nbf[o]) begin
            errors++;
            $display("FAIL backpressure port=%0d act=1 exp=0", o);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int w;
    clk = 0; rst = 1; we = '0; nbf = '0; in_f = '0;
    checks = 0; errors = 0; exp_drop = 0;
    #2;
    chk("rst_wreq", 80'(wreq), 80'd0);
    chk("rst_full", 80'(full), 80'd0);
    chk("rst_drop", 80'(drop), 80'd0);
    chk("rst_out", 80'(out_f), 80'd0);
    @(posedge clk);
    #1;
    rst = 0;

    stage(0, 1, 2, 'hA5, 1);
    tick();
    chk("le_wreq", 80'(wreq), 80'b00100);
    chk("le_out", 80'(out_f[2]), 80'h12A5);
    tick();
    chk("le_idle", 80'(wreq), 80'd0);
    chk("le_hold", 80'(out_f[2]), 80'h12A5);

    stage(1, 1, 1, 'h11, 1);
    stage(4, 1, 1, 'h44, 1);
    tick();
    chk("ct_c1_req", 80'(wreq), 80'b00001);
    chk("ct_c1_flit", 80'(out_f[0]), 80'h1111);
    tick();
    chk("ct_c2_req", 80'(wreq), 80'b00001);
    chk("ct_c2_flit", 80'(out_f[0]), 80'h1144);
    tick();
    chk("ct_idle", 80'(wreq), 80'd0);
    stage(1, 1, 1, 'h22, 1);
    stage(4, 1, 1, 'h55, 1);
    tick();
    chk("ct_ptr0", 80'(out_f[0]), 80'h1122);
    tick();
    tick();

    nbf[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stage(0, 1, 2, 'hB0 + k, k < 4);
      tick();
      if (k == 3) chk("bp_full", 80'(full[0]), 80'd1);
    end
    chk("bp_drop", 80'(drop), 80'd1);
    chk("bp_drop_m", 80'(drop), 80'(exp_drop));
    nbf[2] = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) begin
      chk("bp_req", 80'(wreq[2]), 80'd1);
      chk("bp_flit", 80'(out_f[2]), 80'(16'h12B0 + r));
      if (r == 0) chk("bp_full_hold", 80'(full[0]), 80'd1);
      if (r == 1) chk("bp_full_fall", 80'(full[0]), 80'd0);
      tick();
    end
    chk("bp_idle", 80'(wreq), 80'd0);

    pulse_reset("mr_rst");
    stage(1, 0, 1, 'h77, 1);
    tick();
    chk("mr_wreq", 80'(wreq), 80'd0);
    tick();
    chk("mr_drop1", 80'(drop), 80'd1);
    for (int k = 0; k < 299; k++) begin
      stage(1, 0, 1, k, 1);
      tick();
    end
    tick();
    tick();
    chk("mr_sat", 80'(drop), 80'd255);

    nbf[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stage(3, 1, 1, 'hC0 + k, 1);
      tick();
    end
    chk("mid_nfull", 80'(full[3]), 80'd0);
    chk("mid_blocked", 80'(wreq), 80'd0);
    pulse_reset("mid_rst");
    nbf = '0;
    stage(3, 1, 1, 'hD0, 1);
    tick();
    chk("mid_new_req", 80'(wreq), 80'b00001);
    chk("mid_new_flit", 80'(out_f[0]), 80'h11D0);
    tick();
    chk("mid_empty", 80'(wreq), 80'd0);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int o = 0; o < 5; o++)
        nbf[o] = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < 5; p++) begin
        if (!full[p] && $urandom_range(0, 1) == 1)
          stage(p, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 255), 1);
      end
      tick();
    end
    nbf = '0;
    w = 0;
    while (pending() > 0 && w < 100) begin
      tick();
      w++;
    end
    tick();
    tick();
    tick();
    chk("rnd_drain", 80'(pending()), 80'd0);
    chk("rnd_drop", 80'(drop),
        80'(exp_drop > 255 ? 255 : exp_drop));
    chk("rnd_idle", 80'(wreq), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
